// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one full-subtractor cell plus borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             diff_bit;
    logic             br_next;
    logic             last;
    logic             load;
    logic [WIDTH-1:0] sa_next;

    // Difference bits enter at the top of the minuend register as its bits leave at
    // the bottom, so after WIDTH shifts sa holds the full difference.
    always_comb begin
        diff_bit = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sa_next  = {diff_bit, sa[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                sa  <= a;
                sb  <= b;
                br  <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                sa  <= sa_next;
                sb  <= {1'b0, sb[WIDTH-1:1]};
                br  <= br_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    d    <= sa_next;
                    bout <= br_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor against an a-b model
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_d(input int x, input int y);
        int r;
        r = (x - y) % 256;
        if (r < 0) r = r + 256;
        return WIDTH'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the FSM idle; returns in the same phase, idle again.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        int cyc;
        logic [WIDTH-1:0] prev_d;
        prev_d = d;
        start = 1'b1;
        a = op_a;
        b = op_b;
        tick();
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cyc = 0;
        while (!done && cyc < 40) begin
            check("busy_in_shift", 32'(busy), 32'd1);
            check("d_hold_in_shift", 32'(d), 32'(prev_d));
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(WIDTH));
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("d_value", 32'(d), 32'(model_d(int'(op_a), int'(op_b))));
        check("bout_value", 32'(bout), 32'(op_a < op_b));
        tick();
        check("done_single", 32'(done), 32'd0);
        check("d_hold_idle", 32'(d), 32'(model_d(int'(op_a), int'(op_b))));
    endtask

    initial begin
        int n_done;
        int c_first;
        int c_second;
        logic [WIDTH-1:0] cap_d;
        logic             cap_b;
        logic [WIDTH-1:0] exp_d [2];
        logic             exp_b [2];
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(8'd5, 8'd3);
        run_op(8'd3, 8'd5);
        run_op(8'h00, 8'h01);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'h00);
        run_op(8'h80, 8'h7F);

        // start re-pulsed while busy must be ignored
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        tick();
        a = 8'h55;
        b = 8'h11;
        tick();
        start = 1'b0;
        n_done = 0;
        cap_d = '0;
        cap_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                n_done++;
                cap_d = d;
                cap_b = bout;
            end
            tick();
        end
        check("ignore_done_count", 32'(n_done), 32'd1);
        check("ignore_d", 32'(cap_d), 32'(model_d(16, 32)));
        check("ignore_bout", 32'(cap_b), 32'd1);

        // reset on the 4th shift edge aborts the operation
        run_op(8'h9A, 8'h13);
        start = 1'b1;
        a = 8'h77;
        b = 8'h22;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // start held across DONE: back-to-back second operation
        exp_d[0] = model_d(200, 45);
        exp_b[0] = 1'b0;
        exp_d[1] = model_d(12, 99);
        exp_b[1] = 1'b1;
        start = 1'b1;
        a = 8'd200;
        b = 8'd45;
        tick();
        a = 8'd12;
        b = 8'd99;
        n_done = 0;
        c_first = 0;
        c_second = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (n_done == 1 && !done && start) start = 1'b0;
            if (done) begin
                if (n_done == 0) c_first = c;
                else c_second = c;
                if (n_done < 2) begin
                    check("b2b_d", 32'(d), 32'(exp_d[n_done]));
                    check("b2b_bout", 32'(bout), 32'(exp_b[n_done]));
                end
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd2);
        check("b2b_spacing", 32'(c_second - c_first), 32'(WIDTH + 1));
        tick();
        tick();

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            run_op(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
